sync_fifo_reader: RTL and testbench

Read-side engine for the team's sync_fifo. It issues read requests against the FIFO's read port and absorbs the FIFO's one-cycle read latency in a 2-entry output buffer. It presents the words to a downstream consumer as a valid/ready stream. The block sits between the FIFO output and any stream sink, so sinks never drive the FIFO read port directly.

---
 rtl/sync_fifo_reader.sv | 100 ++++++++++
 tb/tb_sync_fifo_reader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_reader.sv
// Read-side engine for sync_fifo: issues reads, absorbs the one-cycle read latency
// in a 2-entry buffer and presents the words as a valid/ready stream.
module sync_fifo_reader #(
    parameter int p_DATA_WIDTH  = 8,
    parameter int p_COUNT_WIDTH = 16
) (
    input  logic                     i_CLK,
    input  logic                     i_RESET_N,
    input  logic                     i_ENABLE,
    input  logic                     i_FIFO_EMPTY,
    input  logic [p_DATA_WIDTH-1:0]  i_FIFO_DATA,
    output logic                     o_READ_REQUEST,
    output logic [p_DATA_WIDTH-1:0]  o_DATA,
    output logic                     o_VALID,
    input  logic                     i_READY,
    input  logic                     i_CLEAR_COUNT,
    output logic [p_COUNT_WIDTH-1:0] o_WORD_COUNT,
    output logic                     o_BUSY
);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        STOPPING
    } state_e;

    state_e                   state_q, state_d;
    logic [p_DATA_WIDTH-1:0]  mem_q [2];
    logic                     head_q, head_d;
    logic [1:0]               count_q, count_d;
    logic                     inflight_q, inflight_d;
    logic [p_COUNT_WIDTH-1:0] words_q, words_d;

    logic       pop;
    logic       read_req;
    logic       tail;
    logic [1:0] occupancy;

    always_comb begin
        pop        = (count_q != 2'd0) & i_READY;
        // Words that will occupy the buffer after this edge, before any new request.
        occupancy  = count_q + {1'b0, inflight_q} - {1'b0, pop};
        read_req   = (state_q == ACTIVE) & ~i_FIFO_EMPTY & (occupancy < 2'd2);
        tail       = head_q ^ count_q[0];
        count_d    = count_q + {1'b0, inflight_q} - {1'b0, pop};
        head_d     = head_q ^ pop;
        inflight_d = read_req;

        if (i_CLEAR_COUNT) begin
            words_d = p_COUNT_WIDTH'(pop);
        end else begin
            words_d = words_q + p_COUNT_WIDTH'(pop);
        end

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_ENABLE) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (!i_ENABLE) state_d = STOPPING;
            end
            STOPPING: begin
                if (i_ENABLE) begin
                    state_d = ACTIVE;
                end else if ((count_q == 2'd0) && !inflight_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            state_q    <= IDLE;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            head_q     <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            words_q    <= words_d;
            // The in-flight word lands regardless of state; the request rule keeps a slot free.
            if (inflight_q) mem_q[tail] <= i_FIFO_DATA;
        end
    end

    assign o_READ_REQUEST = read_req;
    assign o_DATA         = mem_q[head_q];
    assign o_VALID        = (count_q != 2'd0);
    assign o_BUSY         = (count_q != 2'd0) | inflight_q;
    assign o_WORD_COUNT   = words_q;

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Bench for sync_fifo_reader: behavioural FIFO, word scoreboard and counter model,
// directed phases with randomized data and sink back-pressure.
module tb_sync_fifo_reader;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          rd_req;
    logic [DW-1:0] dout;
    logic          vld;
    logic          rdy;
    logic          clr;
    logic [CW-1:0] wcount;
    logic          busy;

    sync_fifo_reader #(
        .p_DATA_WIDTH (DW),
        .p_COUNT_WIDTH(CW)
    ) dut (
        .i_CLK         (clk),
        .i_RESET_N     (rst_n),
        .i_ENABLE      (en),
        .i_FIFO_EMPTY  (fifo_empty),
        .i_FIFO_DATA   (fifo_data),
        .o_READ_REQUEST(rd_req),
        .o_DATA        (dout),
        .o_VALID       (vld),
        .i_READY       (rdy),
        .i_CLEAR_COUNT (clr),
        .o_WORD_COUNT  (wcount),
        .o_BUSY        (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] fifo_q[$];   // contents of the upstream FIFO
    logic [DW-1:0] sb[$];       // words read from the FIFO, not yet delivered
    logic          req_s = 1'b0;
    int            rd_cnt = 0;
    int            dlv_cnt = 0;
    int            model_cnt = 0;
    logic          hold = 1'b0;
    logic [DW-1:0] hold_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int n;
        n = 0;
        while ((busy || fifo_q.size() != 0) && n < max_cycles) begin
            step();
            n++;
        end
        chk(tag, n < max_cycles, 1);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Registered-flag FIFO: a request seen in a cycle returns its word after the edge.
    initial begin
        forever begin
            @(negedge clk);
            req_s = rd_req && !fifo_empty;
        end
    end

    initial begin
        fifo_empty = 1'b1;
        fifo_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                req_s = 1'b0;
            end else if (req_s && fifo_q.size() != 0) begin
                fifo_data = fifo_q.pop_front();
                sb.push_back(fifo_data);
                rd_cnt++;
            end
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Stream monitor: order, stability under back-pressure, occupancy, busy and counter.
    initial begin
        logic          p;
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("reset_count", wcount, 0);
                model_cnt = 0;
                sb.delete();
                hold = 1'b0;
            end else begin
                chk("req_while_empty", rd_req & fifo_empty, 0);
                chk("occupancy_le2", sb.size() <= 2, 1);
                chk("busy", busy, sb.size() != 0);
                chk("word_count", wcount, model_cnt);
                if (hold) begin
                    chk("hold_valid", vld, 1);
                    chk("hold_data", dout, hold_data);
                end
                p = vld && rdy;
                if (p) begin
                    chk("word_available", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("stream_data", dout, e);
                    end
                    dlv_cnt++;
                end
                model_cnt = clr ? int'(p) : (model_cnt + int'(p)) % (1 << CW);
                hold      = vld && !rdy;
                hold_data = dout;
            end
        end
    end

    initial begin
        int            base_rd;
        int            base_dlv;
        int            n;
        int            pushed;
        logic [DW-1:0] first;
        logic [DW-1:0] w;
        logic          exp_v [8];
        logic [DW-1:0] exp_d [8];
        logic          exp_r [8];

        rst_n = 1'b0;
        en    = 1'b0;
        rdy   = 1'b0;
        clr   = 1'b0;
        #1;
        chk("reset_valid", vld, 0);
        chk("reset_req", rd_req, 0);
        chk("reset_data", dout, 0);
        chk("reset_busy", busy, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Preloaded FIFO, sink always ready: back-to-back delivery from cycle 3
        for (int i = 0; i < 4; i++) fifo_q.push_back(DW'(8'h11 + i));
        rdy = 1'b1;
        step();
        step();
        exp_v = '{0, 0, 0, 1, 1, 1, 1, 0};
        exp_d = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h00};
        exp_r = '{0, 1, 1, 1, 1, 0, 0, 0};
        en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("a_valid_c%0d", c), vld, exp_v[c]);
            chk($sformatf("a_req_c%0d", c), rd_req, exp_r[c]);
            if (exp_v[c]) chk($sformatf("a_data_c%0d", c), dout, exp_d[c]);
        end
        chk("a_count", wcount, 4);
        en = 1'b0;
        wait_idle("a_drain", 20);

        // Eight words with sink stalled: only two fetched, head held
        rdy = 1'b0;
        for (int i = 0; i < 8; i++) fifo_q.push_back(DW'($urandom));
        first = fifo_q[0];
        step();
        step();
        base_rd  = rd_cnt;
        base_dlv = dlv_cnt;
        en = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("b_reads_stalled", rd_cnt - base_rd, 2);
        chk("b_valid_stalled", vld, 1);
        chk("b_head_stalled", dout, first);
        rdy = 1'b1;
        wait_idle("b_drain", 100);
        chk("b_delivered", dlv_cnt - base_dlv, 8);

        // 200 random words, random back-pressure
        base_dlv = dlv_cnt;
        pushed   = 0;
        n        = 0;
        while (pushed < 200 && n < 5000) begin
            rdy = 1'($urandom % 2);
            if ($urandom % 2 == 0) begin
                fifo_q.push_back(DW'($urandom));
                pushed++;
            end
            step();
            n++;
        end
        rdy = 1'b1;
        wait_idle("c_drain", 500);
        chk("c_delivered", dlv_cnt - base_dlv, 200);

        // Enable drops in the request cycle: in-flight word still delivered
        base_dlv = dlv_cnt;
        fifo_q.push_back(8'hA5);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rd_req && n < 10);
        chk("d_req_seen", rd_req, 1);
        en = 1'b0;
        wait_idle("d_drain", 20);
        chk("d_delivered", dlv_cnt - base_dlv, 1);
        chk("d_busy", busy, 0);
        step();
        fifo_q.push_back(8'h5A);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rd_req) n++;
        end
        chk("d_no_requests", n, 0);

        // Counter wrap and clear-with-pop
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("e_cleared", wcount, 0);
        for (int i = 0; i < 16; i++) fifo_q.push_back(DW'($urandom));
        en = 1'b1;
        wait_idle("e_drain", 200);
        chk("e_wrap", wcount, 1);
        rdy = 1'b0;
        fifo_q.push_back(8'h3C);
        n = 0;
        while (!vld && n < 10) begin
            step();
            n++;
        end
        chk("e_valid_wait", vld, 1);
        rdy = 1'b1;
        clr = 1'b1;
        step();
        rdy = 1'b0;
        clr = 1'b0;
        chk("e_clear_with_pop", wcount, 1);

        // Asynchronous reset with two words buffered
        for (int i = 0; i < 3; i++) fifo_q.push_back(DW'(8'h70 + i));
        for (int i = 0; i < 6; i++) step();
        chk("f_valid_before", vld, 1);
        chk("f_busy_before", busy, 1);
        chk("f_head_before", dout, 8'h70);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("f_valid_async", vld, 0);
        chk("f_req_async", rd_req, 0);
        chk("f_busy_async", busy, 0);
        chk("f_count_async", wcount, 0);
        en = 1'b0;
        fifo_q.delete();
        step();
        step();
        rst_n = 1'b1;
        fifo_q.push_back(8'hC3);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rd_req) n++;
        end
        chk("f_idle_no_req", n, 0);
        step();
        en = 1'b1;
        @(negedge clk);
        chk("f_req_cycle0", rd_req, 0);
        @(negedge clk);
        chk("f_req_cycle1", rd_req, 1);
        rdy = 1'b1;
        wait_idle("f_drain", 50);
        en = 1'b0;
        for (int i = 0; i < 3; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
